cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt unit. It is the responder end of the pipeline exception protocol.
- Consumes the per-instruction ExcCode and branch-delay flag that travel down the pipeline registers, plus the external hardware interrupt lines.
- Generates IntReq, which flushes the pipeline registers and redirects fetch to the handler.
- Holds EPC as the eret return target, and services mfc0/mtc0 accesses from the M stage.

Parameters:
PRID_VALUE, 32'h2020_0714, read-only value of PRId (reg 15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
A1  in  5  mfc0 read register number
A2  in  5  mtc0 write register number
DIn  in  32  mtc0 write data
WE  in  1  mtc0 write enable (M stage)
PC  in  32  PC of the instruction currently in M stage
ExcCodeIn  in  5  exception code of M-stage instruction (bits [6:2]); 0 = none
BDIn  in  1  M-stage instruction is in a branch delay slot
HWInt  in  6  external interrupt lines, bit i maps to Cause.IP[i+10]
EXLClr  in  1  eret in M stage
IntReq  out  1  take exception/interrupt this cycle (combinational)
EPC  out  32  current EPC register (eret target)
DOut  out  32  mfc0 read data (combinational)

Behaviour:
- Registers:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC(14): 32 bits, bits [1:0] forced 0.
  - PRId(15) = PRID_VALUE.
  - Any other register number reads 32'h0.
- Reset: SR=0, Cause=0, EPC=0; IntReq=0 the cycle after reset with HWInt=0 and ExcCodeIn=0.
- IntPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcPend = (ExcCodeIn != 0) & ~SR.EXL.
- IntReq = IntPend | ExcPend. This is combinational, zero latency, and seen by the pipeline registers on the same edge.
- Priority: an interrupt outranks a synchronous exception in the same cycle. The ExcCode recorded for an interrupt is 0.
- On a posedge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntPend ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? (PC - 4) : PC, with bits [1:0] cleared.
- Cause.IP <= HWInt on every posedge, regardless of other events. Not writable by mtc0.
- mtc0: on posedge with WE=1 and IntReq=0:
  - A2=12 writes the SR fields only.
  - A2=14 writes EPC, with bits [1:0] cleared.
  - Any other A2 is ignored.
- Conflict WE & IntReq: IntReq wins, the write is discarded.
- eret: on posedge with EXLClr=1 and IntReq=0, SR.EXL <= 0.
  - Conflict EXLClr & IntReq: IntReq wins, EXL stays/becomes 1.
- SR.EXL=1 masks both interrupts and exceptions. A nested exception is not taken; IntReq stays 0.
- Read-during-write: DOut returns the pre-write value; there is no bypass.
- EPC output reflects the registered value. A write to EPC is visible the next cycle.
- Reset asserted in the same cycle as IntReq/WE/EXLClr: reset wins; all state is cleared.

Optional Feature:
CP0_TIMER_EN
- Enabled:
  - Adds Count(9) and Compare(11), 32 bits each, both reset to 0.
  - Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0. mtc0 to 9 loads DIn, and that load overrides the increment that cycle.
  - TimerPend is set when Count == Compare and Compare != 0. It is cleared by an mtc0 to 11.
  - TimerPend is ORed into the HWInt[5] path, i.e. Cause.IP[15] and IntPend.
- Disabled: registers 9 and 11 read 0, writes are ignored, and there is no timer interrupt.

Test Plan:
1. Reset, then write SR with mtc0 A2=12 DIn=32'h0000_FC01, then HWInt=6'b000001 -> IntReq=1 the same cycle. Next cycle: Cause=32'h0000_0400, SR.EXL=1, EPC=PC.
2. ExcCodeIn=5'd10 (RI), BDIn=1, PC=32'h0000_3010, EXL=0 -> IntReq=1. Next cycle: EPC=32'h0000_300C, Cause=32'h8000_0028.
3. HWInt=6'b000100 and ExcCodeIn=5'd4 together, SR.IM=6'h3F, IE=1 -> Cause.ExcCode=0 (interrupt priority), IP[12]=1.
4. EXL=1 with ExcCodeIn=5'd12 -> IntReq=0, EPC unchanged. Then EXLClr=1 -> EXL=0 next cycle, and the pending exception now raises IntReq.
5. WE=1, A2=14, DIn=32'h0000_3003 in the same cycle as IntReq -> EPC=PC, not the write. With no IntReq the same write gives EPC=32'h0000_3000 and DOut(A1=14)=32'h0000_3000 the next cycle.
6. CP0_TIMER_EN: Compare=32'd20, Count=0, IM[15]=1, IE=1 -> IntReq asserts once Count==20. mtc0 to 11 clears IP[15].

Source files
------------

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit: SR, Cause, EPC and PRId, with the IntReq flush/redirect request.
// Define CP0_TIMER_EN to add the Count(9)/Compare(11) timer, which drives the HWInt[5] interrupt path.
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2020_0714
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic [4:0]  ExcCodeIn,
    input  logic        BDIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  srIm_q, srIm_d;
    logic        srExl_q, srExl_d;
    logic        srIe_q, srIe_d;
    logic        causeBd_q, causeBd_d;
    logic [5:0]  causeIp_q, causeIp_d;
    logic [4:0]  causeExc_q, causeExc_d;
    logic [29:0] epc_q, epc_d;

    logic [5:0]  hwEff;
    logic        intPend;
    logic        excPend;
    logic        cpWrite;
    logic [31:0] excEpc;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timerPend_q, timerPend_d;

    assign hwEff = {HWInt[5] | timerPend_q, HWInt[4:0]};
`else
    assign hwEff = HWInt;
`endif

    assign intPend = (|(hwEff & srIm_q)) & srIe_q & ~srExl_q;
    assign excPend = (ExcCodeIn != 5'd0) & ~srExl_q;
    assign IntReq  = intPend | excPend;
    assign cpWrite = WE & ~IntReq;
    assign excEpc  = BDIn ? (PC - 32'd4) : PC;
    assign EPC     = {epc_q, 2'b00};

    always_comb begin
        srIm_d     = srIm_q;
        srExl_d    = srExl_q;
        srIe_d     = srIe_q;
        causeBd_d  = causeBd_q;
        causeIp_d  = hwEff;
        causeExc_d = causeExc_q;
        epc_d      = epc_q;
        if (IntReq) begin
            srExl_d    = 1'b1;
            causeExc_d = intPend ? 5'd0 : ExcCodeIn;
            causeBd_d  = BDIn;
            epc_d      = excEpc[31:2];
        end else begin
            if (cpWrite && A2 == 5'd12) begin
                srIm_d  = DIn[15:10];
                srExl_d = DIn[1];
                srIe_d  = DIn[0];
            end
            if (cpWrite && A2 == 5'd14) begin
                epc_d = DIn[31:2];
            end
            if (EXLClr) begin
                srExl_d = 1'b0;
            end
        end
    end

`ifdef CP0_TIMER_EN
    // A Compare write both loads the register and acknowledges the timer interrupt.
    always_comb begin
        count_d     = count_q + 32'd1;
        compare_d   = compare_q;
        timerPend_d = timerPend_q;
        if (cpWrite && A2 == 5'd9) begin
            count_d = DIn;
        end
        if (cpWrite && A2 == 5'd11) begin
            compare_d   = DIn;
            timerPend_d = 1'b0;
        end else if (count_q == compare_q && compare_q != 32'd0) begin
            timerPend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timerPend_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timerPend_q <= timerPend_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            srIm_q     <= 6'd0;
            srExl_q    <= 1'b0;
            srIe_q     <= 1'b0;
            causeBd_q  <= 1'b0;
            causeIp_q  <= 6'd0;
            causeExc_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            srIm_q     <= srIm_d;
            srExl_q    <= srExl_d;
            srIe_q     <= srIe_d;
            causeBd_q  <= causeBd_d;
            causeIp_q  <= causeIp_d;
            causeExc_q <= causeExc_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        DOut = 32'h0;
        case (A1)
            5'd12:   DOut = {16'h0, srIm_q, 8'h0, srExl_q, srIe_q};
            5'd13:   DOut = {causeBd_q, 15'h0, causeIp_q, 3'h0, causeExc_q, 2'b00};
            5'd14:   DOut = EPC;
            5'd15:   DOut = PRID_VALUE;
`ifdef CP0_TIMER_EN
            5'd9:    DOut = count_q;
            5'd11:   DOut = compare_q;
`endif
            default: DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit; the timer section is built only when CP0_TIMER_EN is defined.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, PC;
    logic        WE, BDIn, EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPC, DOut;

    int assertCount = 0;
    int failCount   = 0;

    cp0_exc_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .ExcCodeIn(ExcCodeIn), .BDIn(BDIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        #1;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [4:0] num, input string tag, input logic [31:0] expected);
        A1 = num;
        #1;
        checkOutput(tag, DOut, expected);
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] a2, input logic [31:0] din,
                                 input logic [4:0] exc, input logic bd, input logic [5:0] hw,
                                 input logic eclr);
        WE = we; A2 = a2; DIn = din; ExcCodeIn = exc; BDIn = bd; HWInt = hw; EXLClr = eclr;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; PC = 32'h0;
        idle();
        tick(); tick();
        reset = 1'b0;
        #1;

        readReg(5'd12, "reset_sr", 32'h0);
        readReg(5'd13, "reset_cause", 32'h0);
        readReg(5'd14, "reset_epc_dout", 32'h0);
        checkOutput("reset_epc", EPC, 32'h0);
        checkOutput("reset_intreq", {31'd0, IntReq}, 32'd0);
        readReg(5'd15, "prid", 32'h2020_0714);
        readReg(5'd3, "unmapped_read", 32'h0);
`ifndef CP0_TIMER_EN
        readReg(5'd9, "count_absent", 32'h0);
        readReg(5'd11, "compare_absent", 32'h0);
`endif

        // Test 1: enable all interrupt lines, then raise HWInt[0].
        applyStimulus(1'b1, 5'd12, 32'h0000_FC01, 5'd0, 1'b0, 6'd0, 1'b0);
        checkOutput("sr_write_no_intreq", {31'd0, IntReq}, 32'd0);
        tick(); idle();
        readReg(5'd12, "sr_after_write", 32'h0000_FC01);
        PC = 32'h0000_1000;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'b000001, 1'b0);
        checkOutput("hwint_intreq", {31'd0, IntReq}, 32'd1);
        tick(); idle();
        readReg(5'd13, "hwint_cause", 32'h0000_0400);
        readReg(5'd12, "hwint_sr_exl", 32'h0000_FC03);
        checkOutput("hwint_epc", EPC, 32'h0000_1000);
        checkOutput("exl_masks_int", {31'd0, IntReq}, 32'd0);

        // Test 2: RI exception in a delay slot.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b1);
        tick(); idle();
        readReg(5'd12, "eret_clears_exl", 32'h0000_FC01);
        PC = 32'h0000_3010;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd10, 1'b1, 6'd0, 1'b0);
        checkOutput("exc_intreq", {31'd0, IntReq}, 32'd1);
        tick(); idle();
        checkOutput("exc_bd_epc", EPC, 32'h0000_300C);
        readReg(5'd13, "exc_bd_cause", 32'h8000_0028);

        // Test 3: interrupt and exception together, interrupt wins.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 1'b0, 6'b000100, 1'b0);
        checkOutput("prio_intreq", {31'd0, IntReq}, 32'd1);
        tick(); idle();
        readReg(5'd13, "prio_cause", 32'h0000_1000);
        checkOutput("prio_epc", EPC, 32'h0000_3010);

        // Test 4: nested exception masked, then taken after eret.
        PC = 32'h0000_5000;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 6'd0, 1'b0);
        checkOutput("nested_masked", {31'd0, IntReq}, 32'd0);
        tick();
        checkOutput("nested_epc_kept", EPC, 32'h0000_3010);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 6'd0, 1'b1);
        checkOutput("eret_cycle_masked", {31'd0, IntReq}, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 6'd0, 1'b0);
        checkOutput("pending_after_eret", {31'd0, IntReq}, 32'd1);
        tick(); idle();
        readReg(5'd13, "pending_cause", 32'h0000_0030);
        checkOutput("pending_epc", EPC, 32'h0000_5000);

        // Test 5: mtc0 EPC discarded under IntReq, honoured otherwise, no read bypass.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b1);
        tick();
        PC = 32'h0000_6000;
        applyStimulus(1'b1, 5'd14, 32'h0000_3003, 5'd8, 1'b0, 6'd0, 1'b0);
        checkOutput("conflict_intreq", {31'd0, IntReq}, 32'd1);
        tick(); idle();
        checkOutput("conflict_epc", EPC, 32'h0000_6000);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd14, 32'h0000_3003, 5'd0, 1'b0, 6'd0, 1'b0);
        readReg(5'd14, "epc_read_during_write", 32'h0000_6000);
        tick(); idle();
        readReg(5'd14, "epc_write_dout", 32'h0000_3000);
        checkOutput("epc_write_out", EPC, 32'h0000_3000);

        // Cause is not writable; SR writes only its fields.
        applyStimulus(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd0, 1'b0, 6'd0, 1'b0);
        tick(); idle();
        readReg(5'd13, "cause_not_writable", 32'h0000_0020);
        applyStimulus(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd0, 1'b0, 6'd0, 1'b0);
        tick(); idle();
        readReg(5'd12, "sr_field_mask", 32'h0000_FC03);

        // Reset overrides a simultaneous exception and write.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd14, 32'h0000_7777, 5'd5, 1'b1, 6'd0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        checkOutput("reset_wins_epc", EPC, 32'h0);
        readReg(5'd12, "reset_wins_sr", 32'h0);
        readReg(5'd13, "reset_wins_cause", 32'h0);

`ifdef CP0_TIMER_EN
        // Test 6: Compare=20, Count loaded with 0; the timer raises IP[15].
        begin
            int waited;
            applyStimulus(1'b1, 5'd12, 32'h0000_8001, 5'd0, 1'b0, 6'd0, 1'b0);
            tick();
            applyStimulus(1'b1, 5'd11, 32'd20, 5'd0, 1'b0, 6'd0, 1'b0);
            tick();
            applyStimulus(1'b1, 5'd9, 32'd0, 5'd0, 1'b0, 6'd0, 1'b0);
            tick(); idle();
            readReg(5'd9, "count_loaded", 32'd0);
            readReg(5'd11, "compare_loaded", 32'd20);
            waited = 0;
            while (!IntReq && waited < 40) begin
                tick();
                waited++;
            end
            checkOutput("timer_intreq", {31'd0, IntReq}, 32'd1);
            checkOutput("timer_latency", waited, 32'd21);
            tick();
            readReg(5'd13, "timer_cause_ip15", 32'h0000_8000);
            applyStimulus(1'b1, 5'd11, 32'd0, 5'd0, 1'b0, 6'd0, 1'b0);
            tick(); idle();
            tick();
            readReg(5'd13, "timer_ip15_cleared", 32'h0000_0000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
